// File: rtl/hash_nonce_ctrl.sv
// hash_nonce_ctrl: walks a nonce range through one micro_ucr_hash core.
// Each nonce is loaded with a one-cycle fill strobe. The controller then waits a fixed
// HASH_LAT cycles, samples H, and compares it against the captured target.
// Optional feature macro: NONCE_LIMIT_EN. It adds a nonce_limit input that ends the search early.
module hash_nonce_ctrl #(
    parameter int NONCE_W  = 32,
    parameter int HASH_LAT = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic                 abort,
    input  logic [127-NONCE_W:0] header,
    input  logic [NONCE_W-1:0]   nonce_start,
    input  logic [23:0]          target,
`ifdef NONCE_LIMIT_EN
    input  logic [NONCE_W-1:0]   nonce_limit,
`endif
    output logic                 fill,
    output logic [127:0]         bloque_in,
    input  logic [23:0]          H,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [NONCE_W-1:0]   nonce_out,
    output logic [23:0]          hash_out
);

    localparam int HDR_W = 128 - NONCE_W;
    localparam int CNT_W = (HASH_LAT > 1) ? $clog2(HASH_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [HDR_W-1:0]   header_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [23:0]        target_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               hit;
    logic               last;
    logic               accept;

    assign accept = (state == S_IDLE) && start && !abort;
    assign hit    = (H < target_q);

`ifdef NONCE_LIMIT_EN
    logic [NONCE_W-1:0] limit_q;
    logic               limit_ok_q;

    // A limit below the start nonce never matches, so it falls back to the all-ones stop.
    assign last = (nonce_q == '1) || (limit_ok_q && (nonce_q == limit_q));
`else
    assign last = (nonce_q == '1);
`endif

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides every state and also drops a start arriving in IDLE
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) next_state = S_LOAD;
                S_LOAD:  next_state = S_WAIT;
                S_WAIT:  if (wait_cnt == '0) next_state = S_CHECK;
                S_CHECK: next_state = (hit || last) ? S_DONE : S_LOAD;
                S_DONE:  next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Captured search parameters, latency counter, nonce stepping and result registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            header_q  <= '0;
            nonce_q   <= '0;
            target_q  <= '0;
            wait_cnt  <= '0;
            found     <= 1'b0;
            nonce_out <= '0;
            hash_out  <= '0;
`ifdef NONCE_LIMIT_EN
            limit_q    <= '0;
            limit_ok_q <= 1'b0;
`endif
        end else if (accept) begin
            header_q <= header;
            nonce_q  <= nonce_start;
            target_q <= target;
            found    <= 1'b0;
`ifdef NONCE_LIMIT_EN
            limit_q    <= nonce_limit;
            limit_ok_q <= (nonce_limit >= nonce_start);
`endif
        end else if (!abort) begin
            case (state)
                S_LOAD: wait_cnt <= CNT_W'(HASH_LAT - 1);
                S_WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                S_CHECK: begin
                    hash_out  <= H;
                    nonce_out <= nonce_q;
                    if (hit) begin
                        found <= 1'b1;
                    end else if (!last) begin
                        nonce_q <= nonce_q + NONCE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore-style strobes; abort masks fill and done in the cycle it is seen
    always_comb begin
        fill      = (state == S_LOAD) && !abort;
        done      = (state == S_DONE) && !abort;
        busy      = (state != S_IDLE);
        bloque_in = {header_q, nonce_q};
    end

endmodule

// File: tb/tb_hash_nonce_ctrl.sv
// Testbench for hash_nonce_ctrl with an 8-bit nonce and a stub hash core.
// The stub core returns H = FFFFFF - nonce exactly HASH_LAT cycles after fill.
// Until then it drives H to zero, so sampling H too early shows up as a false hit.
// The stimulus task queues the expected result of each search.
// A monitor pops and compares that result whenever done pulses.
module tb_hash_nonce_ctrl;

    localparam int NW  = 8;
    localparam int LAT = 8;
    localparam int PER = LAT + 2;

    typedef struct {
        logic        found;
        logic [7:0]  nonce;
        logic [23:0] hash;
        int          fills;
        int          lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_L = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [119:0]    header = '0;
    logic [NW-1:0]   nonce_start = '0;
    logic [23:0]     target = '0;
    logic [NW-1:0]   nonce_limit = '0;
    logic            fill;
    logic [127:0]    bloque_in;
    logic [23:0]     H = '0;
    logic            busy;
    logic            done;
    logic            found;
    logic [NW-1:0]   nonce_out;
    logic [23:0]     hash_out;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              start_cyc = 0;
    int              fill_cnt = 0;

    logic [23:0]     stub_pend = '0;
    int              stub_cnt = 0;

    localparam logic [119:0] HDR_A = 120'h112233445566778899AABBCCDDEEFF;
    localparam logic [119:0] HDR_B = 120'hDEADBEEFCAFEF00D0123456789ABCD;

    hash_nonce_ctrl #(.NONCE_W(NW), .HASH_LAT(LAT)) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .start       (start),
        .abort       (abort),
        .header      (header),
        .nonce_start (nonce_start),
        .target      (target),
`ifdef NONCE_LIMIT_EN
        .nonce_limit (nonce_limit),
`endif
        .fill        (fill),
        .bloque_in   (bloque_in),
        .H           (H),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .nonce_out   (nonce_out),
        .hash_out    (hash_out)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Stub hash core: result appears HASH_LAT edges after fill is sampled
    always @(posedge clk) begin
        if (fill) begin
            stub_pend <= 24'hFFFFFF - {16'h0, bloque_in[7:0]};
            stub_cnt  <= LAT;
            H         <= 24'h0;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) H <= stub_pend;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: counts fill strobes and scores every done pulse against the queue
    always @(negedge clk) begin
        if (reset_L) begin
            if (fill) fill_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 128'(done), 128'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("found", 128'(found), 128'(e.found));
                    checkOutput("nonce_out", 128'(nonce_out), 128'(e.nonce));
                    checkOutput("hash_out", 128'(hash_out), 128'(e.hash));
                    checkOutput("fill_count", 128'(fill_cnt), 128'(e.fills));
                    checkOutput("latency", 128'(cyc - start_cyc + 1), 128'(e.lat));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [119:0] hdr, input logic [7:0] ns, input logic [23:0] tgt,
                                 input logic [7:0] lim, input logic ef, input logic [7:0] en,
                                 input logic [23:0] eh, input int efills, input int elat);
        exp_t e;
        @(posedge clk); #1;
        header      = hdr;
        nonce_start = ns;
        target      = tgt;
        nonce_limit = lim;
        start       = 1'b1;
        start_cyc   = cyc;
        fill_cnt    = 0;
        e.found = ef; e.nonce = en; e.hash = eh; e.fills = efills; e.lat = elat;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_within_budget", 128'(sb.size()), 128'(0));
        sb.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_fill", 128'(fill), 128'(0));
        checkOutput("rst_done", 128'(done), 128'(0));
        checkOutput("rst_bloque", bloque_in, 128'(0));
        checkOutput("rst_results", {found, nonce_out, hash_out}, 128'(0));
        @(negedge clk);
        reset_L = 1'b1;

        // 1: hit on nonce 16 after 17 fills
        applyStimulus(HDR_A, 8'h00, 24'hFFFFF0, 8'h00, 1'b1, 8'h10, 24'hFFFFEF, 17, 17 * PER + 2);
        waitDone(400);
        checkOutput("s1_idle_busy", 128'(busy), 128'(0));
        checkOutput("s1_found_held", 128'(found), 128'(1));

        // 2: target 0 exhausts at all-ones without a fifth fill
        applyStimulus(HDR_B, 8'hFC, 24'h0, 8'h00, 1'b0, 8'hFF, 24'hFFFF00, 4, 4 * PER + 2);
        waitDone(200);
        repeat (3) @(negedge clk);
        checkOutput("s2_no_fifth_fill", 128'(fill_cnt), 128'(4));
        checkOutput("s2_bloque", bloque_in, {HDR_B, 8'hFF});

        // 3: abort in the WAIT phase of the third nonce, then restart from a new nonce_start
        applyStimulus(HDR_A, 8'h20, 24'h0, 8'h00, 1'b0, 8'h00, 24'h0, 0, 0);
        repeat (23) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        checkOutput("s3_fill_on_abort", 128'(fill), 128'(0));
        checkOutput("s3_done_on_abort", 128'(done), 128'(0));
        sb.delete();
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        checkOutput("s3_busy_after_abort", 128'(busy), 128'(0));
        checkOutput("s3_found_kept", 128'(found), 128'(0));
        checkOutput("s3_nonce_out_kept", 128'(nonce_out), 128'(8'h21));
        checkOutput("s3_hash_out_kept", 128'(hash_out), 128'(24'hFFFFDE));
        repeat (12) @(negedge clk);
        checkOutput("s3_fill_stays_low", 128'(fill_cnt), 128'(3));
        applyStimulus(HDR_A, 8'h05, 24'hFFFFFB, 8'h00, 1'b1, 8'h05, 24'hFFFFFA, 1, PER + 2);
        waitDone(100);

        // start and abort together in IDLE: abort wins
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; fill_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checkOutput("start_abort_busy", 128'(busy), 128'(0));
        repeat (3) @(negedge clk);
        checkOutput("start_abort_no_fill", 128'(fill_cnt), 128'(0));

        // 4: start while busy with a different header is ignored
        applyStimulus(HDR_A, 8'h00, 24'hFFFFF0, 8'h00, 1'b1, 8'h10, 24'hFFFFEF, 17, 17 * PER + 2);
        repeat (3) @(posedge clk);
        #1;
        header = HDR_B; nonce_start = 8'h80; target = 24'hFFFFFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        checkOutput("s4_header_kept", 128'(bloque_in[127:8]), 128'(HDR_A));
        checkOutput("s4_nonce_kept", 128'(bloque_in[7:0]), 128'(0));
        waitDone(400);

        // 5: asynchronous reset in the middle of WAIT
        applyStimulus(HDR_B, 8'h40, 24'h0, 8'h00, 1'b0, 8'h00, 24'h0, 0, 0);
        repeat (4) @(posedge clk);
        #3 reset_L = 1'b0;
        #1;
        sb.delete();
        checkOutput("s5_busy", 128'(busy), 128'(0));
        checkOutput("s5_results", {found, nonce_out, hash_out}, 128'(0));
        checkOutput("s5_bloque", bloque_in, 128'(0));
        @(negedge clk);
        reset_L = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("s5_idle_after_release", 128'(busy), 128'(0));
        applyStimulus(HDR_B, 8'hFE, 24'h0, 8'h00, 1'b0, 8'hFF, 24'hFFFF00, 2, 2 * PER + 2);
        waitDone(100);

`ifdef NONCE_LIMIT_EN
        // 6: nonce limit stops the search early; a limit below the start is ignored
        applyStimulus(HDR_A, 8'h05, 24'h0, 8'h07, 1'b0, 8'h07, 24'hFFFFF8, 3, 3 * PER + 2);
        waitDone(100);
        applyStimulus(HDR_A, 8'hFD, 24'h0, 8'h02, 1'b0, 8'hFF, 24'hFFFF00, 3, 3 * PER + 2);
        waitDone(100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
